router_stat_window_collector: RTL
=================================

// Module: router_stat_window_collector
// PURPOSE
//  Successor of the NoC router statistics collector. Counts per-router/per-port flit and packet events
//  over programmable sampling windows, using saturating CNT_W-bit counters. At each window end it
//  snapshots the counts into shadow storage, then streams them out as records over a valid/ready port.
//  Sits beside the NoC in simulation and emulation builds and takes the same router_event bus; it is synthesizable.
// PARAMETERS
//  NOC_ID      0     NoC instance; selects the NOC_CONF config (NR, MAX_P, SMART_NUM)
//  CNT_W       32    width of every counter; counters saturate at 2^CNT_W-1
//  WINDOW_CYC  1024  RUN cycles per window (>=2)
//  PERIODIC    1     1: restart the window automatically after a snapshot; 0: one-shot, return to IDLE
//  NUM_CNT     derived = 6+SMART_NUM+1 (fixed counters + bypass histogram bins)
// PORTS
//  clk           in   1               clock
//  reset         in   1               synchronous, active-high
//  router_event  in   [NR][MAX_P]     router_event_t per router/port
//  start_i       in   1               IDLE->RUN, window counter cleared
//  stop_i        in   1               end the window now (snapshot), enter IDLE
//  clear_i       in   1               zero live counters, shadow, flags
//  dump_req_i    in   1               stream the shadow snapshot
//  rec_valid_o   out  1               record valid
//  rec_ready_i   in   1               record accepted
//  rec_rid_o     out  log2(NR)        router id of the record
//  rec_port_o    out  log2(MAX_P)     port of the record
//  rec_cnt_o     out  NUM_CNT*CNT_W   packed counters, index 0 in LSBs
//  rec_sat_o     out  1               some counter in the record saturated
//  rec_last_o    out  1               final record (r=NR-1, p=MAX_P-1)
//  running_o     out  1               state==RUN
//  window_num_o  out  CNT_W           completed windows (saturating)
//  missed_o      out  1               sticky: a snapshot was skipped during DUMP
// BEHAVIOUR
//  Reset: all counters, shadow, flags, window_num_o=0; state IDLE; rec_valid_o=0; running_o=0.
//  Counter order per (r,p): 0 flit_in, 1 pck_in, 2 flit_out, 3 pck_out, 4 flit_buffered,
//   5 flit_bypassed, 6..6+SMART_NUM bypass bins.
//  Increment rules, evaluated in RUN only:
//   - flit_wr_i -> flit_in; pck_wr_i -> pck_in; flit_wr_o -> flit_out; pck_wr_o -> pck_out.
//   - flit_in_bypassed -> flit_bypassed.
//   - Otherwise, flit_wr_i -> flit_buffered and bin[min(bypassed_num,SMART_NUM)].
//   - An event in cycle t is visible in the live counter at t+1.
//  Saturation: a counter at all-ones holds its value; the entry's sat bit is set. Counters never wrap.
//  FSM states IDLE, RUN, DUMP. Snapshot is a single-cycle action, not a state.
//   - IDLE: start_i -> RUN. dump_req_i -> DUMP at entry (0,0).
//   - RUN: the window counter increments each cycle. At WINDOW_CYC-1, or on stop_i, snapshot:
//     shadow<=live (including the current cycle's events), live<=0, window_num_o++.
//     Then PERIODIC=1 and no stop_i -> stay in RUN, window counter 0. Otherwise -> IDLE.
//     dump_req_i in RUN -> DUMP; counting continues (the live bank is independent of the shadow).
//   - DUMP: rec_valid_o is registered and asserted 1 cycle after entry. It holds its fields stable until
//     rec_valid_o&&rec_ready_i. Indices advance p first, then r. After the last record: valid drops next
//     cycle; return to RUN if the window is still active, else IDLE.
//   - Snapshot due during DUMP: the snapshot is skipped. Live is not cleared (it accumulates into the next
//     window), window_num_o is unchanged, and missed_o is set.
//  Priority in one cycle: reset > clear_i > stop_i/window end > start_i > dump_req_i.
//   - clear_i aborts DUMP (valid low next cycle) and enters IDLE.
//   - start_i in RUN/DUMP and dump_req_i in DUMP are ignored.
//  Reset mid-DUMP: rec_valid_o=0 next cycle; the record is lost and no partial handshake is allowed.
// STRUCTURE
//  pronoc_pkg: router_event_t (existing), stat_cnt_idx_e enum, STAT_FIX_CNT=6 constant.
//  Sub-module router_port_stat_cnt: one (r,p) bank of live+shadow counters and sat bit.
//   Ports: en, snap, clr, ev, shadow_o. Instantiated NR*MAX_P times by generate.
//  The top level holds the FSM, window counter, dump index and output mux.
// TESTING
//  1. NR=4, MAX_P=5, WINDOW_CYC=100. Start; router 2 port 1 gets a 3-flit packet at cycles 10-12.
//     -> dump: (2,1) flit_in=3, pck_in=1, flit_buffered=3, bin0=3; all other records 0.
//  2. CNT_W=4, flit_wr_i high for 20 cycles -> flit_in=15, rec_sat_o=1, no wrap.
//  3. PERIODIC=1, 350 cycles, 1 flit/cycle on (0,0) -> window_num_o=3; shadow flit_in=100.
//  4. rec_ready_i toggling 1-in-3 -> NR*MAX_P records, fields stable while stalled, rec_last_o only on (3,4).
//  5. Window end during DUMP -> missed_o=1, window_num_o unchanged, next snapshot holds 2 windows of counts.
//  6. clear_i and stop_i together mid-DUMP -> valid low next cycle, all counters 0, IDLE;
//     separately, reset mid-DUMP -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/router_stat_window_collector_pkg.sv
// Shared types and NoC configuration lookup for the router statistics window collector.
// NOC_ID selects router count, port count and SMART bypass depth.
package router_stat_window_collector_pkg;

   localparam int unsigned STAT_FIX_CNT = 6;
   localparam int unsigned BYP_NUM_W    = 4;

   typedef struct packed {
      logic                 flit_wr_i;
      logic                 pck_wr_i;
      logic                 flit_wr_o;
      logic                 pck_wr_o;
      logic                 flit_in_bypassed;
      logic [BYP_NUM_W-1:0] bypassed_num;
   } router_event_t;

   typedef enum logic [3:0] {
      CntFlitIn       = 4'd0,
      CntPckIn        = 4'd1,
      CntFlitOut      = 4'd2,
      CntPckOut       = 4'd3,
      CntFlitBuffered = 4'd4,
      CntFlitBypassed = 4'd5,
      CntBin0         = 4'd6
   } stat_cnt_idx_e;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDump
   } collector_state_e;

   function automatic int unsigned noc_nr(input int unsigned noc_id);
      return (noc_id == 1) ? 16 : 4;
   endfunction

   function automatic int unsigned noc_max_p(input int unsigned noc_id);
      return (noc_id == 1) ? 5 : 5;
   endfunction

   function automatic int unsigned noc_smart_num(input int unsigned noc_id);
      return (noc_id == 1) ? 4 : 2;
   endfunction

   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/router_stat_window_collector_port_cnt.sv
// One (router, port) bank: live saturating counters plus the shadow snapshot and its sat bit.
module router_port_stat_cnt
   import router_stat_window_collector_pkg::*;
#(
   parameter int unsigned CNT_W     = 32,
   parameter int unsigned SMART_NUM = 2,
   localparam int unsigned NUM_CNT  = STAT_FIX_CNT + SMART_NUM + 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     en,
   input  logic                     snap,
   input  logic                     clr,
   input  router_event_t            ev,
   output logic [NUM_CNT*CNT_W-1:0] shadow_o,
   output logic                     shadow_sat_o
);

   localparam int unsigned SelW = idx_w(NUM_CNT);
   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

   logic [NUM_CNT-1:0] inc;
   logic [SelW-1:0]    bin_sel;
   logic [CNT_W-1:0]   live_q   [NUM_CNT];
   logic [CNT_W-1:0]   live_d   [NUM_CNT];
   logic [CNT_W-1:0]   shadow_q [NUM_CNT];
   logic               live_sat_q, live_sat_d, shadow_sat_q;

   always_comb begin
      inc     = '0;
      bin_sel = '0;
      // Deeper bypass chains than SMART_NUM all land in the top bin.
      if (ev.bypassed_num > BYP_NUM_W'(SMART_NUM)) begin
         bin_sel = SelW'(STAT_FIX_CNT + SMART_NUM);
      end else begin
         bin_sel = SelW'(STAT_FIX_CNT) + SelW'(ev.bypassed_num);
      end
      inc[SelW'(CntFlitIn)]  = ev.flit_wr_i;
      inc[SelW'(CntPckIn)]   = ev.pck_wr_i;
      inc[SelW'(CntFlitOut)] = ev.flit_wr_o;
      inc[SelW'(CntPckOut)]  = ev.pck_wr_o;
      if (ev.flit_in_bypassed) begin
         inc[SelW'(CntFlitBypassed)] = 1'b1;
      end else if (ev.flit_wr_i) begin
         inc[SelW'(CntFlitBuffered)] = 1'b1;
         inc[bin_sel]                = 1'b1;
      end
   end

   always_comb begin
      live_sat_d = live_sat_q;
      for (int k = 0; k < NUM_CNT; k++) begin
         live_d[k] = live_q[k];
         if (en && inc[k]) begin
            if (live_q[k] == CntMax) begin
               live_sat_d = 1'b1;
            end else begin
               live_d[k] = live_q[k] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         live_q       <= '{default: '0};
         shadow_q     <= '{default: '0};
         live_sat_q   <= 1'b0;
         shadow_sat_q <= 1'b0;
      end else if (snap) begin
         // Snapshot includes this cycle's events; live restarts from zero.
         shadow_q     <= live_d;
         shadow_sat_q <= live_sat_d;
         live_q       <= '{default: '0};
         live_sat_q   <= 1'b0;
      end else begin
         live_q     <= live_d;
         live_sat_q <= live_sat_d;
      end
   end

   for (genvar k = 0; k < NUM_CNT; k++) begin : g_pack
      assign shadow_o[k*CNT_W +: CNT_W] = shadow_q[k];
   end

   assign shadow_sat_o = shadow_sat_q;

endmodule

// File: rtl/router_stat_window_collector.sv
// Windowed NoC router statistics collector: per-port counter banks, window FSM and
// a valid/ready record stream that walks the shadow snapshot port-first, then router.
module router_stat_window_collector
   import router_stat_window_collector_pkg::*;
#(
   parameter int unsigned NOC_ID     = 0,
   parameter int unsigned CNT_W      = 32,
   parameter int unsigned WINDOW_CYC = 1024,
   parameter int unsigned PERIODIC   = 1,
   localparam int unsigned NR        = noc_nr(NOC_ID),
   localparam int unsigned MAX_P     = noc_max_p(NOC_ID),
   localparam int unsigned SMART_NUM = noc_smart_num(NOC_ID),
   localparam int unsigned NUM_CNT   = STAT_FIX_CNT + SMART_NUM + 1,
   localparam int unsigned RID_W     = idx_w(NR),
   localparam int unsigned PORT_W    = idx_w(MAX_P)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  router_event_t            router_event [NR][MAX_P],
   input  logic                     start_i,
   input  logic                     stop_i,
   input  logic                     clear_i,
   input  logic                     dump_req_i,
   output logic                     rec_valid_o,
   input  logic                     rec_ready_i,
   output logic [RID_W-1:0]         rec_rid_o,
   output logic [PORT_W-1:0]        rec_port_o,
   output logic [NUM_CNT*CNT_W-1:0] rec_cnt_o,
   output logic                     rec_sat_o,
   output logic                     rec_last_o,
   output logic                     running_o,
   output logic [CNT_W-1:0]         window_num_o,
   output logic                     missed_o
);

   localparam int unsigned NumBanks = NR * MAX_P;
   localparam int unsigned BankW    = idx_w(NumBanks);
   localparam int unsigned WinW     = idx_w(WINDOW_CYC);
   localparam logic [WinW-1:0] WinLast = WinW'(WINDOW_CYC - 1);
   localparam bit Periodic = (PERIODIC != 0);

   collector_state_e    state_q, state_d;
   logic                win_active_q, win_active_d;
   logic [WinW-1:0]     win_cnt_q, win_cnt_d;
   logic [CNT_W-1:0]    win_num_q, win_num_d;
   logic                missed_q, missed_d;
   logic                valid_q, valid_d;
   logic [RID_W-1:0]    rid_q, rid_d;
   logic [PORT_W-1:0]   port_q, port_d;
   logic                snap, win_end, at_last, keep_running;
   logic [BankW-1:0]    bank_idx;

   logic [NUM_CNT*CNT_W-1:0] shadow_all [NumBanks];
   logic                     sat_all    [NumBanks];

   assign win_end      = win_active_q && (stop_i || (win_cnt_q == WinLast));
   assign keep_running = Periodic && !stop_i;
   assign at_last      = (rid_q == RID_W'(NR - 1)) && (port_q == PORT_W'(MAX_P - 1));

   always_comb begin
      state_d      = state_q;
      win_active_d = win_active_q;
      win_cnt_d    = win_cnt_q;
      win_num_d    = win_num_q;
      missed_d     = missed_q;
      valid_d      = valid_q;
      rid_d        = rid_q;
      port_d       = port_q;
      snap         = 1'b0;

      if (clear_i) begin
         state_d      = StIdle;
         win_active_d = 1'b0;
         win_cnt_d    = '0;
         win_num_d    = '0;
         missed_d     = 1'b0;
         valid_d      = 1'b0;
         rid_d        = '0;
         port_d       = '0;
      end else begin
         if (win_active_q && !win_end) begin
            win_cnt_d = win_cnt_q + 1'b1;
         end
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  state_d      = StRun;
                  win_active_d = 1'b1;
                  win_cnt_d    = '0;
               end else if (dump_req_i) begin
                  state_d = StDump;
                  valid_d = 1'b1;
                  rid_d   = '0;
                  port_d  = '0;
               end
            end
            StRun: begin
               if (win_end) begin
                  snap      = 1'b1;
                  win_cnt_d = '0;
                  if (win_num_q != {CNT_W{1'b1}}) begin
                     win_num_d = win_num_q + 1'b1;
                  end
                  if (!keep_running) begin
                     state_d      = StIdle;
                     win_active_d = 1'b0;
                  end
               end else if (dump_req_i) begin
                  state_d = StDump;
                  valid_d = 1'b1;
                  rid_d   = '0;
                  port_d  = '0;
               end
            end
            StDump: begin
               // Shadow is being streamed: skip the snapshot, let live carry over.
               if (win_end) begin
                  missed_d  = 1'b1;
                  win_cnt_d = '0;
                  if (!keep_running) begin
                     win_active_d = 1'b0;
                  end
               end
               if (valid_q && rec_ready_i) begin
                  if (at_last) begin
                     valid_d = 1'b0;
                     rid_d   = '0;
                     port_d  = '0;
                     state_d = win_active_d ? StRun : StIdle;
                  end else if (port_q == PORT_W'(MAX_P - 1)) begin
                     port_d = '0;
                     rid_d  = rid_q + 1'b1;
                  end else begin
                     port_d = port_q + 1'b1;
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         win_active_q <= 1'b0;
         win_cnt_q    <= '0;
         win_num_q    <= '0;
         missed_q     <= 1'b0;
         valid_q      <= 1'b0;
         rid_q        <= '0;
         port_q       <= '0;
      end else begin
         state_q      <= state_d;
         win_active_q <= win_active_d;
         win_cnt_q    <= win_cnt_d;
         win_num_q    <= win_num_d;
         missed_q     <= missed_d;
         valid_q      <= valid_d;
         rid_q        <= rid_d;
         port_q       <= port_d;
      end
   end

   for (genvar r = 0; r < NR; r++) begin : g_router
      for (genvar p = 0; p < MAX_P; p++) begin : g_port
         router_port_stat_cnt #(
            .CNT_W     (CNT_W),
            .SMART_NUM (SMART_NUM)
         ) u_bank (
            .clk          (clk),
            .reset        (reset),
            .en           (win_active_q),
            .snap         (snap),
            .clr          (clear_i),
            .ev           (router_event[r][p]),
            .shadow_o     (shadow_all[r*MAX_P+p]),
            .shadow_sat_o (sat_all[r*MAX_P+p])
         );
      end
   end

   assign bank_idx     = BankW'(rid_q) * BankW'(MAX_P) + BankW'(port_q);
   assign rec_valid_o  = valid_q;
   assign rec_rid_o    = rid_q;
   assign rec_port_o   = port_q;
   assign rec_cnt_o    = shadow_all[bank_idx];
   assign rec_sat_o    = sat_all[bank_idx];
   assign rec_last_o   = valid_q && at_last;
   assign running_o    = (state_q == StRun);
   assign window_num_o = win_num_q;
   assign missed_o     = missed_q;

endmodule
